// File: rtl/ps2_scancode_sequencer.sv
//------------------------------------------------------------------------------
// Module   : ps2_scancode_sequencer
// Purpose  : Validates PS/2 Set-2 frames, folds E0/F0 prefixes into single key
//            events and queues them in a show-ahead valid/ready FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_scancode_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 100000,
  parameter int ERR_W          = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             frame_valid,
  input  logic [10:0]      frame_code,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_release,
  output logic             frame_err,
  output logic             timeout,
  output logic             bat_ok,
  output logic             bat_err,
  output logic             overflow,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int              c_aw    = $clog2(FIFO_DEPTH);
  localparam int              c_tw    = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_tw-1:0] c_tmax  = c_tw'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_REL     = 2'd2,
    S_EXT_REL = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_fv_d;
  logic [c_tw-1:0]   r_tmr;
  logic [9:0]        r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic              r_frame_err;
  logic              r_timeout;
  logic              r_bat_ok;
  logic              r_bat_err;
  logic              r_overflow;
  logic [ERR_W-1:0]  r_err_cnt;

  logic              w_accept;
  logic [7:0]        w_byte;
  logic              w_frame_ok;
  logic              w_is_e0;
  logic              w_is_f0;
  logic              w_tmr_exp;
  logic              w_push;
  logic              w_push_ext;
  logic              w_push_rel;
  logic              w_ferr;
  logic              w_to;
  logic              w_bok;
  logic              w_berr;
  logic              w_pop;
  logic              w_full;
  logic              w_wr_en;

  // Rising edge of frame_valid only, so a held flag yields one frame.
  assign w_accept   = frame_valid & ~r_fv_d;
  assign w_byte     = frame_code[8:1];
  assign w_frame_ok = ~frame_code[0] & frame_code[10] & (^frame_code[9:1]);
  assign w_is_e0    = (w_byte == 8'hE0);
  assign w_is_f0    = (w_byte == 8'hF0);
  assign w_tmr_exp  = (r_state != S_IDLE) && (r_tmr == c_tmax);

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_ext  = 1'b0;
    w_push_rel  = 1'b0;
    w_ferr      = 1'b0;
    w_to        = 1'b0;
    w_bok       = 1'b0;
    w_berr      = 1'b0;
    if (w_accept) begin
      if (!w_frame_ok) begin
        w_ferr      = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_is_e0)               w_state_nxt = S_EXT;
            else if (w_is_f0)          w_state_nxt = S_REL;
            else if (w_byte == 8'hAA)  w_bok       = 1'b1;
            else if (w_byte == 8'hFC)  w_berr      = 1'b1;
            else                       w_push      = 1'b1;
          end
          S_EXT: begin
            if (w_is_f0) begin
              w_state_nxt = S_EXT_REL;
            end else if (!w_is_e0) begin
              w_push      = 1'b1;
              w_push_ext  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          S_REL, S_EXT_REL: begin
            w_state_nxt = S_IDLE;
            if (w_is_e0 || w_is_f0) begin
              w_ferr = 1'b1;
            end else begin
              w_push     = 1'b1;
              w_push_ext = (r_state == S_EXT_REL);
              w_push_rel = 1'b1;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end else if (w_tmr_exp) begin
      w_to        = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_fv_d      <= 1'b0;
      r_tmr       <= '0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
      r_bat_ok    <= 1'b0;
      r_bat_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fv_d      <= frame_valid;
      r_frame_err <= w_ferr;
      r_timeout   <= w_to;
      r_bat_ok    <= w_bok;
      r_bat_err   <= w_berr;
      if (w_accept || w_tmr_exp || (r_state == S_IDLE)) r_tmr <= '0;
      else                                                r_tmr <= r_tmr + c_tw'(1);
      if (w_ferr && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign evt_valid = (r_count != '0);
  assign w_pop     = evt_valid & evt_ready;
  assign w_full    = (r_count == c_depth);
  assign w_wr_en   = w_push & (~w_full | w_pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= {w_byte, w_push_ext, w_push_rel};
        r_wr_ptr        <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + (c_aw + 1)'(1);
        2'b01:   r_count <= r_count - (c_aw + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr_en) r_overflow <= 1'b1;
    end
  end

  assign {evt_code, evt_ext, evt_release} = r_mem[r_rd_ptr];
  assign frame_err = r_frame_err;
  assign timeout   = r_timeout;
  assign bat_ok    = r_bat_ok;
  assign bat_err   = r_bat_err;
  assign overflow  = r_overflow;
  assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_ps2_scancode_sequencer
// Purpose  : Randomized and directed self-checking bench against a queue model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_scancode_sequencer;

  localparam int DEPTH = 4;
  localparam int PT    = 20;
  localparam int EW    = 3;

  logic          clk         = 1'b0;
  logic          rst         = 1'b0;
  logic          frame_valid = 1'b0;
  logic [10:0]   frame_code  = '0;
  logic          evt_ready   = 1'b0;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_release;
  logic          frame_err;
  logic          timeout;
  logic          bat_ok;
  logic          bat_err;
  logic          overflow;
  logic [EW-1:0] err_cnt;

  always #5 clk = ~clk;

  ps2_scancode_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .PREFIX_TIMEOUT (PT),
    .ERR_W          (EW)
  ) u_dut (
    .CLK         (clk),
    .RST         (rst),
    .frame_valid (frame_valid),
    .frame_code  (frame_code),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_ext     (evt_ext),
    .evt_release (evt_release),
    .frame_err   (frame_err),
    .timeout     (timeout),
    .bat_ok      (bat_ok),
    .bat_err     (bat_err),
    .overflow    (overflow),
    .err_cnt     (err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending prefix flags, age since the last frame, event queue.
  bit         m_fv_d;
  bit         m_ext;
  bit         m_rel;
  int         m_age;
  logic [9:0] m_q[$];
  bit         e_ferr, e_to, e_bok, e_berr, e_ovf;
  int         e_cnt;

  task automatic model_reset();
    m_fv_d = 0; m_ext = 0; m_rel = 0; m_age = 0;
    m_q.delete();
    e_ferr = 0; e_to = 0; e_bok = 0; e_berr = 0; e_ovf = 0; e_cnt = 0;
  endtask

  task automatic model_edge(input bit fv, input logic [10:0] fc, input bit rdy);
    bit         pop, acc, ok, push;
    logic [7:0] b;
    logic [9:0] item;
    pop    = (m_q.size() != 0) && rdy;
    acc    = fv && !m_fv_d;
    m_fv_d = fv;
    e_ferr = 0; e_to = 0; e_bok = 0; e_berr = 0;
    push   = 0;
    item   = '0;
    b      = fc[8:1];
    ok     = (fc[0] == 1'b0) && (fc[10] == 1'b1) && ((^fc[9:1]) == 1'b1);
    if (acc) begin
      m_age = 0;
      if (!ok) begin
        e_ferr = 1; m_ext = 0; m_rel = 0;
      end else if (!m_ext && !m_rel) begin
        if (b == 8'hE0)      m_ext = 1;
        else if (b == 8'hF0) m_rel = 1;
        else if (b == 8'hAA) e_bok = 1;
        else if (b == 8'hFC) e_berr = 1;
        else begin push = 1; item = {b, 2'b00}; end
      end else if (m_rel) begin
        if (b == 8'hE0 || b == 8'hF0) e_ferr = 1;
        else begin push = 1; item = {b, m_ext, 1'b1}; end
        m_ext = 0; m_rel = 0;
      end else begin
        if (b == 8'hF0) m_rel = 1;
        else if (b != 8'hE0) begin
          push = 1; item = {b, 2'b10}; m_ext = 0;
        end
      end
    end else if (m_ext || m_rel) begin
      m_age++;
      if (m_age == PT) begin
        e_to = 1; m_ext = 0; m_rel = 0;
      end
    end
    if (e_ferr && e_cnt < (1 << EW) - 1) e_cnt++;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(item);
      else                    e_ovf = 1;
    end
  endtask

  task automatic compare_outputs();
    check("evt_valid", evt_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("evt_code", evt_code, m_q[0][9:2]);
      check("evt_ext", evt_ext, m_q[0][1]);
      check("evt_release", evt_release, m_q[0][0]);
    end
    check("frame_err", frame_err, e_ferr);
    check("timeout", timeout, e_to);
    check("bat_ok", bat_ok, e_bok);
    check("bat_err", bat_err, e_berr);
    check("overflow", overflow, e_ovf);
    check("err_cnt", err_cnt, e_cnt);
  endtask

  task automatic tick(input bit fv, input logic [10:0] fc, input bit rdy);
    frame_valid = fv;
    frame_code  = fc;
    evt_ready   = rdy;
    model_edge(fv, fc, rdy);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    frame_valid = 1'b0;
    evt_ready   = 1'b0;
    rst         = 1'b1;
    model_reset();
    @(negedge clk);
    compare_outputs();
    check("rst_evt_code", evt_code, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input int bad);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    case (bad)
      1:       f[9]  = ~f[9];
      2:       f[0]  = 1'b1;
      3:       f[10] = 1'b0;
      default: f     = f;
    endcase
    return f;
  endfunction

  function automatic bit rdy_of(input int mode);
    return (mode == 2) ? bit'($urandom_range(0, 1)) : bit'(mode);
  endfunction

  // rmode: 0/1 fixed evt_ready, 2 random per cycle.
  task automatic send(input logic [7:0] b, input int bad, input int hold, input int gap, input int rmode);
    logic [10:0] f;
    f = mkframe(b, bad);
    repeat (hold) tick(1'b1, f, rdy_of(rmode));
    repeat (gap)  tick(1'b0, f, rdy_of(rmode));
  endtask

  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'hFC,
                            8'h1C, 8'h75, 8'h16, 8'h1E, 8'h26, 8'h2E};

  initial begin
    #1;
    do_reset();

    // Basic event then pop
    send(8'h1C, 0, 1, 1, 0);
    tick(1'b0, '0, 1'b1);
    // Release, extended release with long-held frame_valid
    send(8'hF0, 0, 1, 1, 1);
    send(8'h1C, 0, 1, 2, 1);
    send(8'hE0, 0, 5, 1, 0);
    send(8'hF0, 0, 5, 1, 0);
    send(8'h75, 0, 5, 1, 0);
    tick(1'b0, '0, 1'b1);
    // Bad parity, and a bad frame cancelling a prefix
    send(8'h1C, 1, 1, 2, 1);
    send(8'hE0, 0, 1, 1, 1);
    send(8'h00, 2, 1, 1, 1);
    send(8'h75, 0, 1, 2, 1);
    // Protocol error: F0 E0
    send(8'hF0, 0, 1, 1, 1);
    send(8'hE0, 0, 1, 2, 1);
    // Prefix timeout, then BAT codes
    send(8'hE0, 0, 1, PT + 5, 1);
    send(8'h75, 0, 1, 2, 1);
    send(8'hAA, 0, 1, 2, 1);
    send(8'hFC, 0, 1, 2, 1);
    // Frame arriving on the exact expiry edge
    send(8'hE0, 0, 1, PT - 1, 1);
    send(8'h75, 0, 1, 2, 1);
    // Overflow with a stalled consumer, then push and pop on a full FIFO
    send(8'h16, 0, 1, 1, 0);
    send(8'h1E, 0, 1, 1, 0);
    send(8'h26, 0, 1, 1, 0);
    send(8'h25, 0, 1, 1, 0);
    send(8'h2E, 0, 1, 1, 0);
    send(8'h36, 0, 1, 1, 1);
    repeat (6) tick(1'b0, '0, 1'b1);
    // Reset in the middle of a prefix sequence
    send(8'hE0, 0, 1, 1, 1);
    do_reset();
    send(8'h75, 0, 1, 2, 1);
    // Error counter saturation
    for (int i = 0; i < 9; i++) send(8'h5A, 1 + (i % 3), 1, 1, 1);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      int         bad, gap;
      b   = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(PT - 3, PT + 3))
                                        : int'($urandom_range(1, 3));
      send(b, bad, int'($urandom_range(1, 4)), gap, 2);
      if (i == 200) do_reset();
    end
    repeat (8) tick(1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
